// File: rtl/avalon_mm_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single shared slave.
// Round-robin on ties, a hold counter that forces hand-over after MAX_HOLD
// consecutive granted cycles, a lock input that pins the grant, and routing
// of one-cycle-latency read data back to the master that issued the read.
//
// Handshake: a master command (read or write) is accepted in any cycle where
// that master's waitrequest is 0 and its read or write strobe is 1; while its
// waitrequest is 1 the master keeps address, strobes and write data stable.
// readdatavalid is a one-cycle pulse with no back-pressure.
module avalon_mm_arbiter #(
  parameter int ASZ      = 4,
  parameter int DSZ      = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  // master 0
  input  logic [ASZ-1:0] m0_addr,
  input  logic           m0_read,
  input  logic           m0_write,
  input  logic [DSZ-1:0] m0_write_data,
  input  logic           m0_lock,
  output logic           m0_waitrequest,
  output logic [DSZ-1:0] m0_read_data,
  output logic           m0_readdatavalid,
  // master 1
  input  logic [ASZ-1:0] m1_addr,
  input  logic           m1_read,
  input  logic           m1_write,
  input  logic [DSZ-1:0] m1_write_data,
  input  logic           m1_lock,
  output logic           m1_waitrequest,
  output logic [DSZ-1:0] m1_read_data,
  output logic           m1_readdatavalid,
  // shared slave
  output logic [ASZ-1:0] s_addr,
  output logic           s_read,
  output logic           s_write,
  output logic [DSZ-1:0] s_write_data,
  input  logic [DSZ-1:0] s_read_data,
  // debug: current arbiter state (0 = IDLE, 1 = GRANT0, 2 = GRANT1)
  output logic [1:0]     dbg_state_o
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            gnt0_q, gnt1_q;      // registered grant decode
  logic            last_grant_q;        // master that most recently got a grant
  logic [HW-1:0]   hold_q, hold_d;      // consecutive cycles in the current grant
  logic            pend_q;              // read issued last cycle, data due now
  logic            pend_owner_q;        // master that issued that read

  logic req0, req1;
  logic acc_read;
  logic g0, g1;

  assign req0 = m0_read | m0_write | m0_lock;
  assign req1 = m1_read | m1_write | m1_lock;

  // A read is accepted whenever the granted master strobes read.
  assign acc_read = (gnt0_q & m0_read) | (gnt1_q & m1_read);

  // Next-state and hold-counter computation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0: begin
        if (!req0)                                             state_d = req1 ? GRANT1 : IDLE;
        else if (!m0_lock && (hold_q == HOLD_LAST) && req1)   state_d = GRANT1;
      end
      GRANT1: begin
        if (!req1)                                             state_d = req0 ? GRANT0 : IDLE;
        else if (!m1_lock && (hold_q == HOLD_LAST) && req0)   state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    hold_d = hold_q;
    if (state_d != state_q)                          hold_d = '0;
    else if (state_q != IDLE && hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
  end

  // Arbiter state, registered grant flags, round-robin memory and read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      last_grant_q <= 1'b1;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      pend_owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= (state_d == GRANT0);
      gnt1_q  <= (state_d == GRANT1);
      if (state_d == GRANT0) last_grant_q <= 1'b0;
      if (state_d == GRANT1) last_grant_q <= 1'b1;
      hold_q       <= hold_d;
      pend_q       <= acc_read;
      pend_owner_q <= gnt1_q;
    end
  end

  // Output decode; reset forces every output to its idle value immediately.
  always_comb begin
    g0 = gnt0_q & ~rst;
    g1 = gnt1_q & ~rst;

    m0_waitrequest = ~g0;
    m1_waitrequest = ~g1;

    s_addr       = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_write_data = '0;
    if (g0) begin
      s_addr       = m0_addr;
      s_read       = m0_read;
      s_write      = m0_write;
      s_write_data = m0_write_data;
    end else if (g1) begin
      s_addr       = m1_addr;
      s_read       = m1_read;
      s_write      = m1_write;
      s_write_data = m1_write_data;
    end

    m0_readdatavalid = pend_q & ~pend_owner_q & ~rst;
    m1_readdatavalid = pend_q &  pend_owner_q & ~rst;
    m0_read_data     = m0_readdatavalid ? s_read_data : '0;
    m1_read_data     = m1_readdatavalid ? s_read_data : '0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Bench for avalon_mm_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_avalon_mm_arbiter;

  localparam int ASZ  = 4;
  localparam int DSZ  = 16;
  localparam int MAXH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT signals ----------------
  logic [ASZ-1:0] addr [2];
  logic           rd   [2];
  logic           wr   [2];
  logic           lk   [2];
  logic [DSZ-1:0] wdat [2];
  logic [DSZ-1:0] s_rdata;

  logic           m0_wait, m1_wait, m0_rdv, m1_rdv;
  logic [DSZ-1:0] m0_rdat, m1_rdat;
  logic [ASZ-1:0] s_addr;
  logic           s_read, s_write;
  logic [DSZ-1:0] s_wdata;
  logic [1:0]     dbg;

  avalon_mm_arbiter #(.ASZ(ASZ), .DSZ(DSZ), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_write_data(wdat[0]), .m0_lock(lk[0]),
    .m0_waitrequest(m0_wait), .m0_read_data(m0_rdat), .m0_readdatavalid(m0_rdv),
    .m1_addr(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_write_data(wdat[1]), .m1_lock(lk[1]),
    .m1_waitrequest(m1_wait), .m1_read_data(m1_rdat), .m1_readdatavalid(m1_rdv),
    .s_addr(s_addr), .s_read(s_read), .s_write(s_write),
    .s_write_data(s_wdata), .s_read_data(s_rdata),
    .dbg_state_o(dbg)
  );

  // ---------------- reference model ----------------
  int  m_owner;        // -1 = nobody granted, else master index
  int  m_last;         // master granted most recently
  int  m_hold;         // granted cycles so far in the current grant
  bit  m_pend;         // read data due this cycle
  int  m_pend_owner;
  bit  force_beef;
  logic [DSZ-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs of the ending cycle.
  task automatic model_step();
    bit rq [2];
    int nxt;
    int o;
    int x;
    logic [DSZ-1:0] v;
    for (int n = 0; n < 2; n++) rq[n] = rd[n] | wr[n] | lk[n];
    if (rst) begin
      m_owner = -1; m_last = 1; m_hold = 0; m_pend = 0; m_pend_owner = 0;
    end else begin
      m_pend = 0;
      if (m_owner >= 0) begin
        m_pend       = rd[m_owner];
        m_pend_owner = m_owner;
      end
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) nxt = 1 - m_last;
        else if (rq[0])     nxt = 0;
        else if (rq[1])     nxt = 1;
        else                nxt = -1;
      end else begin
        o = m_owner;
        x = 1 - o;
        if (!rq[o])                                       nxt = rq[x] ? x : -1;
        else if (!lk[o] && m_hold == MAXH - 1 && rq[x])   nxt = x;
        else                                              nxt = o;
      end
      if (nxt != m_owner)                        m_hold = 0;
      else if (m_owner >= 0 && m_hold < MAXH - 1) m_hold++;
      if (nxt >= 0 && nxt != m_owner) m_last = nxt;
      m_owner = nxt;
    end
    // slave: data for an accepted read appears the following cycle
    if (m_pend) begin
      v = force_beef ? 16'hBEEF : DSZ'($urandom);
      force_beef = 0;
      exp_q.push_back(v);
      s_rdata = v;
    end else begin
      s_rdata = DSZ'($urandom);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    logic [DSZ-1:0] pdata;
    logic [ASZ-1:0] e_addr;
    logic           e_rd, e_wr;
    logic [DSZ-1:0] e_wd;
    bit v0, v1;
    pdata = '0;
    if (m_pend) begin
      chk("sb_has_entry", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) pdata = exp_q.pop_front();
    end
    chk("m0_waitrequest", m0_wait, (rst || m_owner != 0));
    chk("m1_waitrequest", m1_wait, (rst || m_owner != 1));
    e_addr = '0; e_rd = 0; e_wr = 0; e_wd = '0;
    if (!rst && m_owner >= 0) begin
      e_addr = addr[m_owner]; e_rd = rd[m_owner];
      e_wr = wr[m_owner];     e_wd = wdat[m_owner];
    end
    chk("s_addr", s_addr, e_addr);
    chk("s_read", s_read, e_rd);
    chk("s_write", s_write, e_wr);
    chk("s_write_data", s_wdata, e_wd);
    v0 = m_pend && !rst && m_pend_owner == 0;
    v1 = m_pend && !rst && m_pend_owner == 1;
    chk("m0_readdatavalid", m0_rdv, v0);
    chk("m1_readdatavalid", m1_rdv, v1);
    chk("m0_read_data", m0_rdat, v0 ? pdata : '0);
    chk("m1_read_data", m1_rdat, v1 ? pdata : '0);
    chk("state", dbg, (m_owner < 0) ? 0 : m_owner + 1);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check mid-cycle, advance model at the edge, return #1 after it.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_all();
    for (int n = 0; n < 2; n++) begin
      rd[n] = 0; wr[n] = 0; lk[n] = 0; addr[n] = '0; wdat[n] = '0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  waits;
    int  cnt;
    bit  done;
    bit  acc;
    clear_all();
    s_rdata = '0;
    force_beef = 0;
    m_owner = -1; m_last = 1; m_hold = 0; m_pend = 0; m_pend_owner = 0;

    // reset
    rst = 1;
    repeat (3) cycle();
    chk("rst_state", dbg, 0);
    chk("rst_m0_wait", m0_wait, 1);
    rst = 0;
    cycle();

    // single master: write then read
    addr[0] = 4'd0; wdat[0] = 16'h27FA; wr[0] = 1;
    waits = 0; done = 0;
    for (int i = 0; i < 20; i++) begin
      acc = (m_owner == 0);
      if (acc) begin
        chk("s1_wr_addr", s_addr, 0);
        chk("s1_wr_data", s_wdata, 16'h27FA);
        chk("s1_wr_strobe", s_write, 1);
        cycle();
        done = 1;
        break;
      end
      waits++;
      cycle();
    end
    chk("s1_accepted", done, 1);
    chk("s1_wait_cycles", waits, 1);
    wr[0] = 0; rd[0] = 1; addr[0] = 4'd4;
    #1;
    chk("s1_rd_addr", s_addr, 4);
    chk("s1_rd_strobe", s_read, 1);
    cycle();
    rd[0] = 0;
    #1;
    chk("s1_rdv", m0_rdv, 1);
    chk("s1_rdata", m0_rdat, s_rdata);
    chk("s1_m1_rdv", m1_rdv, 0);
    repeat (2) cycle();

    // tie after reset
    rst = 1; cycle(); rst = 0;
    wr[0] = 1; wr[1] = 1; addr[0] = 4'd1; addr[1] = 4'd2;
    wdat[0] = 16'h1111; wdat[1] = 16'h2222;
    cycle();
    chk("tie_first_grant", dbg, 1);
    cycle();
    wr[0] = 0;
    cycle();
    chk("tie_handover_no_idle", dbg, 2);
    cycle();
    wr[1] = 0;
    cycle();
    chk("tie_back_idle", dbg, 0);
    wr[0] = 1; wr[1] = 1;
    cycle();
    chk("tie_second_grant", dbg, 1);
    cycle();
    wr[0] = 0; wr[1] = 0;
    repeat (2) cycle();

    // starvation / forced hand-over
    wr[0] = 1; addr[0] = 4'd3;
    cycle();
    wr[1] = 1;
    cnt = 0; done = 0;
    for (int i = 0; i < 40; i++) begin
      wdat[0] = DSZ'($urandom);
      #1;
      if (dbg == 2) begin done = 1; break; end
      if (m0_wait == 0) cnt++;
      cycle();
    end
    chk("starve_handover", done, 1);
    chk("starve_m0_cycles", cnt, MAXH);
    chk("starve_m0_wait", m0_wait, 1);
    wr[0] = 0;
    cycle();
    wr[1] = 0;
    repeat (2) cycle();

    // lock pins the grant
    lk[0] = 1; wr[1] = 1;
    cycle();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (dbg == 1) cnt++;
      cycle();
    end
    chk("lock_no_handover", cnt, 20);
    lk[0] = 0;
    cycle();
    chk("lock_release_g1", dbg, 2);
    wr[1] = 0;
    repeat (2) cycle();

    // read accepted on the forced hand-over cycle
    rd[0] = 1; addr[0] = 4'd5;
    cycle();
    wr[1] = 1;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_owner == 0 && m_hold == MAXH - 1) begin
        force_beef = 1;
        cycle();
        done = 1;
        break;
      end
      cycle();
    end
    chk("ho_reached", done, 1);
    chk("ho_m0_rdv", m0_rdv, 1);
    chk("ho_m0_rdata", m0_rdat, 16'hBEEF);
    chk("ho_m1_rdv", m1_rdv, 0);
    chk("ho_state", dbg, 2);
    rd[0] = 0;
    cycle();
    wr[1] = 0;
    repeat (2) cycle();

    // reset in the cycle after a read acceptance
    rd[0] = 1; addr[0] = 4'd6;
    cycle();
    cycle();
    rst = 1; rd[0] = 0;
    #1;
    chk("rstrd_m0_rdv", m0_rdv, 0);
    chk("rstrd_m0_wait", m0_wait, 1);
    cycle();
    chk("rstrd_state", dbg, 0);
    chk("rstrd_after_rdv", m0_rdv, 0);
    rst = 0;
    cycle();

    // random traffic; a master keeps its command until it is accepted
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!((rd[n] || wr[n]) && m_owner != n)) begin
          int k;
          k = $urandom_range(0, 3);
          rd[n]   = (k == 1);
          wr[n]   = (k == 2);
          addr[n] = ASZ'($urandom);
          wdat[n] = DSZ'($urandom);
        end
        if ($urandom_range(0, 7) == 0) lk[n] = ~lk[n];
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear_all();
    rst = 0;
    repeat (3) cycle();
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
